clk_period_monitor: RTL and testbench
=====================================

// Module: clk_period_monitor
// PURPOSE
// - Downstream consumer of the high/low-time clock tester in the MMCM DRP bring-up path.
// - Samples the tester's ht/lt counts once per slow-clock period and forms period = ht+lt+2.
//   The two edge cycles are not counted by the tester, hence the +2.
// - Averages 2**LOG2_AVG samples, compares the average to a programmable target window,
//   and asserts freq_ok after LOCK_CNT consecutive good windows. Detects a stalled slow clock.
// PARAMETERS
// - LOG2_AVG  2       log2 of samples per averaging window (0..8)
// - LOCK_CNT  3       consecutive in-range windows required to assert freq_ok (1..15)
// - DISCARD   2       samples dropped after reset/enable/stall recovery (partial phases)
// - TIMEOUT   65536   clk_fst cycles without a clk_slw rising edge before the stall is declared
// PORTS
// - clk_fst       in   1      measurement clock; all logic lives in this domain
// - reset_n       in   1      asynchronous active-low reset
// - clk_slw       in   1      slow clock under test, already synchronised to clk_fst
// - en            in   1      monitor enable; low forces S_DISCARD, clears counters
// - ht_in         in   16     tester high-time count
// - lt_in         in   16     tester low-time count
// - target        in   18     expected period in clk_fst cycles
// - tol           in   18     allowed +/- deviation of averaged period
// - period_avg    out  18     last window average period (sum >> LOG2_AVG)
// - high_avg      out  16     last window average ht_in
// - result_valid  out  1      1-cycle pulse when period_avg/high_avg update
// - freq_ok       out  1      frequency locked inside window
// - stalled       out  1      no slow edge for TIMEOUT cycles
// BEHAVIOUR
// - Reset: all outputs 0, state S_DISCARD, accumulators/counters 0.
// - Edge detect: slw_d <= clk_slw. Rise = !slw_d & clk_slw.
//   - sample_stb fires 2 cycles after rise, when ht_in/lt_in hold a matched high/low pair.
//   - A new rise within those 2 cycles restarts the delay; the pending strobe is dropped.
// - Sample period p = ht_in + lt_in + 2 (18 bit, no overflow).
//   - ht_in==16'hFFFF or lt_in==16'hFFFF means the tester count wrapped: mark window bad
//     but still count the sample.
// - S_DISCARD: count strobes; after DISCARD strobes -> S_ACCUM.
// - S_ACCUM: psum += p (18+LOG2_AVG bits), hsum += ht_in, scnt++.
//   - Window full -> S_EVAL.
// - S_EVAL (exactly 1 cycle):
//   - Latch period_avg and high_avg; pulse result_valid.
//   - In range: |period_avg - target| <= tol, computed signed 19 bit, target/tol sampled this
//     cycle only, and no bad flag. Then okcnt++ (saturating at LOCK_CNT); otherwise okcnt = 0.
//   - freq_ok = (okcnt == LOCK_CNT) after update; drops on the first bad window.
//   - A strobe coinciding with S_EVAL seeds the next window (psum = p, scnt = 1).
//   - -> S_ACCUM.
// - Stall: idle counter clears on every rise and counts otherwise.
//   - Reaching TIMEOUT sets stalled=1, clears freq_ok/okcnt/accumulators, -> S_STALL.
// - S_STALL: first rise clears stalled -> S_DISCARD. period_avg/high_avg hold.
// - en low, any state: -> S_DISCARD, clear okcnt/freq_ok/stalled/accumulators.
//   Outputs period_avg/high_avg hold.
// - reset_n assertion mid-window: immediate clear; no result_valid for the partial window.
// STRUCTURE
// - Package clk_mon_pkg holds:
//   - state enum {S_DISCARD, S_ACCUM, S_EVAL, S_STALL}
//   - PERIOD_W=18 and CNT_W=16 constants
// - One sub-module: clk_mon_edge_strobe (rise detect + 2-cycle sample delay + timeout counter).
// - Averaging/compare/FSM stay in the top.
// TESTING
// - clk_fst 100 MHz, clk_slw 10 MHz 50% (ht=lt=4), target=10, tol=0, defaults:
//   - result_valid every 4 slow periods; period_avg=10, high_avg=4.
//   - freq_ok rises with the 3rd result_valid (14th post-reset sample).
// - Locked, then switch clk_slw to 8-cycle period:
//   - next full window gives period_avg=8; freq_ok falls with that result_valid.
//   - Relock after 3 more windows with target=8.
// - Locked, hold clk_slw low 65536 cycles:
//   - stalled=1 and freq_ok=0 on the TIMEOUT cycle.
//   - Restart clk_slw: stalled clears at first rise; 2 samples discarded before accumulation.
// - Drive ht_in=16'hFFFF for one sample of a window: that window not in range, okcnt=0.
//   The next clean window restarts the lock count.
// - Assert reset_n low mid-window (async, between clock edges):
//   - all outputs 0 immediately; no result_valid until DISCARD+4 samples after release.
// - Toggle en low for 1 cycle while locked: freq_ok=0 next cycle; period_avg holds its value.

Source files
------------

// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_mon_pkg
// Purpose  : Shared types, widths and helpers for the clock period monitor.
// Revision : 1.0 - initial release
// ============================================================================
package clk_mon_pkg;

  localparam int PERIOD_W = 18;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    S_DISCARD = 2'd0,
    S_ACCUM   = 2'd1,
    S_EVAL    = 2'd2,
    S_STALL   = 2'd3
  } state_t;

  // One slow-clock period in fast-clock cycles; the two edge cycles the
  // tester does not count are added back here.
  function automatic logic [PERIOD_W-1:0] sample_period(
    input logic [CNT_W-1:0] ht,
    input logic [CNT_W-1:0] lt
  );
    return {2'b00, ht} + {2'b00, lt} + PERIOD_W'(2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_mon_edge_strobe.sv
`default_nettype none
// ============================================================================
// Module   : clk_mon_edge_strobe
// Purpose  : Slow-clock rise detect, delayed sample strobe and stall timer.
// Revision : 1.0 - initial release
// ============================================================================
module clk_mon_edge_strobe #(
  parameter int TIMEOUT = 65536
) (
  input  logic clk_fst,
  input  logic reset_n,
  input  logic clk_slw,
  output logic rise,
  output logic sample_stb,
  output logic stall_hit
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] c_idle_max = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] c_idle_hit = IDLE_W'(TIMEOUT - 1);

  logic              r_slw_d;
  logic [1:0]        r_dly;
  logic [IDLE_W-1:0] r_idle;

  assign rise       = clk_slw & ~r_slw_d;
  // The tester needs two cycles after a rise before its ht/lt pair matches.
  assign sample_stb = (r_dly == 2'd1);
  // One-shot: the idle counter parks at TIMEOUT so this fires once per stall.
  assign stall_hit  = (r_idle == c_idle_hit) & ~rise;

  // Delay the slow clock by one cycle for edge detection.
  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n) r_slw_d <= 1'b0;
    else          r_slw_d <= clk_slw;
  end

  // Sample delay: a rise (re)loads the countdown, dropping any pending strobe.
  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n)              r_dly <= 2'd0;
    else if (rise)             r_dly <= 2'd2;
    else if (r_dly != 2'd0)    r_dly <= r_dly - 2'd1;
  end

  // Idle timer: cleared by every rise, saturates at TIMEOUT otherwise.
  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n)                 r_idle <= '0;
    else if (rise)                r_idle <= '0;
    else if (r_idle != c_idle_max) r_idle <= r_idle + IDLE_W'(1);
  end

endmodule
`default_nettype wire

// File: rtl/clk_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_period_monitor
// Purpose  : Averages tester ht/lt samples into a period, checks it against a
//            target window, reports lock and slow-clock stall.
// Revision : 1.0 - initial release
// ============================================================================
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int LOG2_AVG = 2,
  parameter int LOCK_CNT = 3,
  parameter int DISCARD  = 2,
  parameter int TIMEOUT  = 65536
) (
  input  logic                clk_fst,
  input  logic                reset_n,
  input  logic                clk_slw,
  input  logic                en,
  input  logic [CNT_W-1:0]    ht_in,
  input  logic [CNT_W-1:0]    lt_in,
  input  logic [PERIOD_W-1:0] target,
  input  logic [PERIOD_W-1:0] tol,
  output logic [PERIOD_W-1:0] period_avg,
  output logic [CNT_W-1:0]    high_avg,
  output logic                result_valid,
  output logic                freq_ok,
  output logic                stalled
);

  localparam int SUM_W  = PERIOD_W + LOG2_AVG;
  localparam int HSUM_W = CNT_W + LOG2_AVG;
  localparam int SCNT_W = LOG2_AVG + 1;
  localparam int DCNT_W = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam logic [SCNT_W-1:0] c_win_last  = SCNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [DCNT_W-1:0] c_disc_last = DCNT_W'(DISCARD - 1);
  localparam logic [3:0]        c_lock      = 4'(LOCK_CNT);

  state_t              r_state, w_state_nxt;
  logic [SUM_W-1:0]    r_psum;
  logic [HSUM_W-1:0]   r_hsum;
  logic [SCNT_W-1:0]   r_scnt;
  logic [DCNT_W-1:0]   r_dcnt;
  logic                r_bad;
  logic [3:0]          r_okcnt;
  logic [PERIOD_W-1:0] r_period_avg;
  logic [CNT_W-1:0]    r_high_avg;
  logic                r_result_valid, r_freq_ok, r_stalled;

  logic                w_rise, w_stb, w_stall_hit;
  logic [PERIOD_W-1:0] w_p, w_avg;
  logic [CNT_W-1:0]    w_havg;
  logic                w_wrap, w_in_range;
  logic signed [PERIOD_W:0] w_diff;
  logic [PERIOD_W:0]   w_absdiff;
  logic                w_clear, w_stall_set, w_stall_clr, w_eval, w_accum;
  logic [3:0]          w_ok_nxt;

  clk_mon_edge_strobe #(.TIMEOUT(TIMEOUT)) u_edge (
    .clk_fst    (clk_fst),
    .reset_n    (reset_n),
    .clk_slw    (clk_slw),
    .rise       (w_rise),
    .sample_stb (w_stb),
    .stall_hit  (w_stall_hit)
  );

  assign w_p        = sample_period(ht_in, lt_in);
  assign w_wrap     = (ht_in == 16'hFFFF) | (lt_in == 16'hFFFF);
  assign w_avg      = r_psum[LOG2_AVG +: PERIOD_W];
  assign w_havg     = r_hsum[LOG2_AVG +: CNT_W];
  assign w_diff     = $signed({1'b0, w_avg}) - $signed({1'b0, target});
  assign w_absdiff  = w_diff[PERIOD_W] ? PERIOD_W'(0) - w_diff : w_diff;
  assign w_in_range = (w_absdiff <= {1'b0, tol}) & ~r_bad;
  assign w_ok_nxt   = (r_okcnt == c_lock) ? c_lock : r_okcnt + 4'd1;

  // State register.
  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n) r_state <= S_DISCARD;
    else          r_state <= w_state_nxt;
  end

  // Next state: disable beats stall, stall beats normal sequencing.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = S_DISCARD;
    end else if (w_stall_hit && r_state != S_STALL) begin
      w_state_nxt = S_STALL;
    end else begin
      case (r_state)
        S_DISCARD: if (w_stb && r_dcnt == c_disc_last) w_state_nxt = S_ACCUM;
        S_ACCUM:   if (w_stb && r_scnt == c_win_last)  w_state_nxt = S_EVAL;
        S_EVAL:    w_state_nxt = S_ACCUM;
        S_STALL:   if (w_rise) w_state_nxt = S_DISCARD;
        default:   w_state_nxt = S_DISCARD;
      endcase
    end
  end

  // Control decode for the datapath.
  always_comb begin
    w_stall_set = en & w_stall_hit & (r_state != S_STALL);
    w_clear     = ~en | w_stall_set;
    w_stall_clr = en & (r_state == S_STALL) & w_rise;
    w_eval      = ~w_clear & (r_state == S_EVAL);
    w_accum     = ~w_clear & (r_state == S_ACCUM) & w_stb;
  end

  // Discard counter only runs while discarding.
  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n)                          r_dcnt <= '0;
    else if (!en || r_state != S_DISCARD)  r_dcnt <= '0;
    else if (w_stb)                        r_dcnt <= r_dcnt + DCNT_W'(1);
  end

  // Window accumulators; a strobe landing on the eval cycle seeds the next window.
  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n) begin
      r_psum <= '0; r_hsum <= '0; r_scnt <= '0; r_bad <= 1'b0;
    end else if (w_clear) begin
      r_psum <= '0; r_hsum <= '0; r_scnt <= '0; r_bad <= 1'b0;
    end else if (w_eval) begin
      r_psum <= w_stb ? SUM_W'(w_p)    : '0;
      r_hsum <= w_stb ? HSUM_W'(ht_in) : '0;
      r_scnt <= w_stb ? SCNT_W'(1)     : '0;
      r_bad  <= w_stb & w_wrap;
    end else if (w_accum) begin
      r_psum <= r_psum + SUM_W'(w_p);
      r_hsum <= r_hsum + HSUM_W'(ht_in);
      r_scnt <= r_scnt + SCNT_W'(1);
      r_bad  <= r_bad | w_wrap;
    end
  end

  // Results, lock tracking and stall flag.
  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n) begin
      r_period_avg <= '0; r_high_avg <= '0; r_result_valid <= 1'b0;
      r_okcnt <= '0; r_freq_ok <= 1'b0; r_stalled <= 1'b0;
    end else begin
      r_result_valid <= w_eval;
      if (w_eval) begin
        r_period_avg <= w_avg;
        r_high_avg   <= w_havg;
      end
      if (w_clear) begin
        r_okcnt   <= '0;
        r_freq_ok <= 1'b0;
      end else if (w_eval) begin
        r_okcnt   <= w_in_range ? w_ok_nxt : 4'd0;
        r_freq_ok <= w_in_range & (w_ok_nxt == c_lock);
      end
      if (!en)              r_stalled <= 1'b0;
      else if (w_stall_set) r_stalled <= 1'b1;
      else if (w_stall_clr) r_stalled <= 1'b0;
    end
  end

  assign period_avg   = r_period_avg;
  assign high_avg     = r_high_avg;
  assign result_valid = r_result_valid;
  assign freq_ok      = r_freq_ok;
  assign stalled      = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_clk_period_monitor
// Purpose  : Directed self-checking bench with a sample-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_period_monitor;

  localparam int TIMEOUT = 65536;
  localparam int DISCARD = 2;

  logic        clk_fst = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_slw = 1'b0;
  logic        en      = 1'b1;
  logic [15:0] ht_in   = '0;
  logic [15:0] lt_in   = '0;
  logic [17:0] target  = 18'd10;
  logic [17:0] tol     = 18'd0;
  logic [17:0] period_avg;
  logic [15:0] high_avg;
  logic        result_valid, freq_ok, stalled;

  clk_period_monitor dut (
    .clk_fst(clk_fst), .reset_n(reset_n), .clk_slw(clk_slw), .en(en),
    .ht_in(ht_in), .lt_in(lt_in), .target(target), .tol(tol),
    .period_avg(period_avg), .high_avg(high_avg), .result_valid(result_valid),
    .freq_ok(freq_ok), .stalled(stalled)
  );

  always #5 clk_fst = ~clk_fst;

  int     checks = 0, failures = 0, rv_count = 0;
  longint cyc = 0, last_rise = 0;
  always @(posedge clk_fst) cyc <= cyc + 1;

  typedef struct { int pavg; int havg; bit fok; } exp_t;
  exp_t sb[$];

  // Sample-level reference model.
  int     m_disc, m_n, m_ok;
  bit     m_accum, m_bad;
  longint m_psum, m_hsum;

  function automatic void model_clear();
    m_disc = 0; m_n = 0; m_ok = 0; m_accum = 0; m_bad = 0; m_psum = 0; m_hsum = 0;
  endfunction

  function automatic void model_sample(int ht, int lt);
    longint avg, diff;
    exp_t   e;
    bit     inr;
    if (!m_accum) begin
      m_disc++;
      if (m_disc == DISCARD) m_accum = 1;
      return;
    end
    m_psum += ht + lt + 2;
    m_hsum += ht;
    m_bad  |= (ht == 65535) || (lt == 65535);
    m_n++;
    if (m_n == 4) begin
      avg  = m_psum / 4;
      diff = avg - longint'(target);
      if (diff < 0) diff = -diff;
      inr  = (diff <= longint'(tol)) && !m_bad;
      m_ok = inr ? ((m_ok < 3) ? m_ok + 1 : 3) : 0;
      e.pavg = int'(avg); e.havg = int'(m_hsum / 4); e.fok = (m_ok == 3);
      sb.push_back(e);
      m_n = 0; m_psum = 0; m_hsum = 0; m_bad = 0;
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_fst);
    #1;
  endtask

  // One slow period: high h cycles, low l cycles, tester reports ht/lt.
  task automatic slow_cycle(int h, int l, int ht, int lt);
    ht_in = 16'(ht); lt_in = 16'(lt);
    model_sample(ht, lt);
    clk_slw = 1'b1; last_rise = cyc;
    tick(h);
    clk_slw = 1'b0;
    tick(l);
  endtask

  task automatic slow_run(int n, int h, int l, int ht, int lt);
    for (int i = 0; i < n; i++) slow_cycle(h, l, ht, lt);
  endtask

  // Scoreboard consumer: every result_valid pops one expected window.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_fst);
      if (result_valid === 1'b1) begin
        rv_count++;
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL rv_unexpected observed=1 expected=0");
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("period_avg", 32'(period_avg), 32'(e.pavg));
          check("high_avg",   32'(high_avg),   32'(e.havg));
          check("freq_ok_rv", 32'(freq_ok),    32'(e.fok));
        end
      end
    end
  end

  initial begin
    int     n, rv0;
    longint elapsed;
    model_clear();
    tick(3);
    check("rst_period_avg", 32'(period_avg), 0);
    check("rst_high_avg",   32'(high_avg), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_freq_ok",    32'(freq_ok), 0);
    check("rst_stalled",    32'(stalled), 0);
    reset_n = 1'b1;
    tick(2);

    // 10-cycle slow clock, lock with the 3rd window.
    slow_run(14, 5, 5, 4, 4);
    check("lock_10", 32'(freq_ok), 1);
    slow_run(4, 5, 5, 4, 4);

    // Switch to 8-cycle period: lock drops, then relock on target 8.
    slow_run(4, 4, 4, 3, 3);
    check("unlock_8", 32'(freq_ok), 0);
    target = 18'd8;
    slow_run(12, 4, 4, 3, 3);
    check("relock_8", 32'(freq_ok), 1);

    // Stall: hold the slow clock low.
    n = 0;
    while (stalled !== 1'b1 && n < 70000) begin tick(1); n++; end
    elapsed = cyc - last_rise;
    check("stall_seen", 32'(stalled), 1);
    check("stall_time", 32'(elapsed), 32'(TIMEOUT + 1));
    check("stall_freq_ok", 32'(freq_ok), 0);
    check("stall_hold_avg", 32'(period_avg), 8);
    model_clear();
    tick(20);
    check("stall_persist", 32'(stalled), 1);

    // Restart at 10 cycles: stall clears, 2 discards, then lock again.
    target = 18'd10;
    slow_cycle(5, 5, 4, 4);
    check("stall_clear", 32'(stalled), 0);
    slow_run(13, 5, 5, 4, 4);
    check("relock_after_stall", 32'(freq_ok), 1);

    // Wrapped tester count poisons one window; lock count restarts.
    slow_cycle(5, 5, 4, 4);
    slow_cycle(5, 5, 65535, 4);
    slow_run(2, 5, 5, 4, 4);
    check("wrap_unlock", 32'(freq_ok), 0);
    slow_run(8, 5, 5, 4, 4);
    check("wrap_still_counting", 32'(freq_ok), 0);
    slow_run(4, 5, 5, 4, 4);
    check("wrap_relock", 32'(freq_ok), 1);

    // Asynchronous reset in the middle of a window.
    slow_run(2, 5, 5, 4, 4);
    #2 reset_n = 1'b0;
    #1;
    check("arst_period_avg", 32'(period_avg), 0);
    check("arst_high_avg", 32'(high_avg), 0);
    check("arst_freq_ok", 32'(freq_ok), 0);
    check("arst_stalled", 32'(stalled), 0);
    check("arst_result_valid", 32'(result_valid), 0);
    model_clear();
    tick(3);
    reset_n = 1'b1;
    tick(2);
    rv0 = rv_count;
    slow_run(5, 5, 5, 4, 4);
    check("arst_no_early_rv", 32'(rv_count - rv0), 0);
    slow_cycle(5, 5, 4, 4);
    check("arst_first_rv", 32'(rv_count - rv0), 1);
    slow_run(8, 5, 5, 4, 4);
    check("arst_relock", 32'(freq_ok), 1);

    // One-cycle disable while locked.
    tick(2);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    check("en_freq_ok", 32'(freq_ok), 0);
    check("en_hold_avg", 32'(period_avg), 10);
    model_clear();
    slow_run(6, 5, 5, 4, 4);

    tick(10);
    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
